// File: rtl/lock_reg_bank_if.sv
// Write request / response channel of the lock register bank.
// The master issues writes and consumes responses; the bank is the slave.
interface lock_reg_bank_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_err;

    modport master (
        output wr_valid, wr_addr, wr_data, rsp_ready,
        input  wr_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rsp_ready,
        output wr_ready, rsp_valid, rsp_err
    );
endinterface

// File: rtl/lock_reg_bank.sv
// Bank of security configuration registers with per-register lock modes
// (lock-gated, write-once, monotonic), sticky locks and a violation counter.
module lock_reg_bank #(
    parameter int unsigned          NUM_REGS = 8,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [2*NUM_REGS-1:0] MODE    = '0,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0,
    parameter int unsigned          CNT_W    = 8,
    localparam int unsigned         ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    lock_reg_bank_if.slave             io_bus,
    input  logic                       i_lock_set,
    input  logic [ADDR_W-1:0]          i_lock_idx,
    input  logic                       i_lock_all,
    output logic [NUM_REGS*DATA_W-1:0] o_reg_q,
    output logic [NUM_REGS-1:0]        o_lock_q,
    output logic [CNT_W-1:0]           o_viol_count,
    output logic                       o_viol_irq,
    input  logic                       i_viol_clr
);
    typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrLocked   = 2'b01;
    localparam logic [1:0] ErrRollback = 2'b10;
    localparam logic [1:0] ErrBadAddr  = 2'b11;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;
    logic                r_lock_all;
    logic [1:0]          r_rsp_err;
    logic [CNT_W-1:0]    r_viol_count;
    logic                r_viol_irq;

    logic [NUM_REGS-1:0] w_lock_set_vec;
    logic [NUM_REGS-1:0] w_sel;
    logic [NUM_REGS-1:0] w_once_mode;
    logic [NUM_REGS-1:0] w_once_set;
    logic [DATA_W-1:0]   w_cur;
    logic                w_lock_eff;
    logic                w_mono;
    logic [1:0]          w_err;
    logic                w_commit;
    logic                w_viol;

    // Decode the captured address; lock requests arriving this cycle count toward the
    // effective lock so that locking always wins over a concurrent write.
    always_comb begin
        w_lock_set_vec = '0;
        w_sel          = '0;
        w_once_mode    = '0;
        w_cur          = '0;
        w_lock_eff     = 1'b0;
        w_mono         = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            w_once_mode[i] = (MODE[2*i +: 2] == 2'b01);
            if (i_lock_set && (int'(i_lock_idx) == i)) begin
                w_lock_set_vec[i] = 1'b1;
            end
            if (int'(r_addr) == i) begin
                w_sel[i]   = 1'b1;
                w_cur      = r_regs[i];
                w_lock_eff = r_lock[i] | r_lock_all | i_lock_all | w_lock_set_vec[i];
                w_mono     = (MODE[2*i +: 2] == 2'b10);
            end
        end
    end

    always_comb begin
        w_err = ErrOk;
        if (w_sel == '0) begin
            w_err = ErrBadAddr;
        end else if (w_lock_eff) begin
            w_err = ErrLocked;
        end else if (w_mono && (r_data < w_cur)) begin
            w_err = ErrRollback;
        end
    end

    assign w_commit   = (r_state == StCheck) && (w_err == ErrOk);
    assign w_viol     = (r_state == StCheck) && (w_err != ErrOk);
    assign w_once_set = w_once_mode & w_sel & {NUM_REGS{w_commit}};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (io_bus.wr_valid) w_state_next = StCheck;
            StCheck: w_state_next = StResp;
            StResp:  if (io_bus.rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_data       <= '0;
            r_lock       <= '0;
            r_lock_all   <= 1'b0;
            r_rsp_err    <= ErrOk;
            r_viol_count <= '0;
            r_viol_irq   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && io_bus.wr_valid) begin
                r_addr <= io_bus.wr_addr;
                r_data <= io_bus.wr_data;
            end
            r_lock <= r_lock | w_lock_set_vec | w_once_set;
            if (i_lock_all) begin
                r_lock_all <= 1'b1;
            end
            if (r_state == StCheck) begin
                r_rsp_err <= w_err;
            end
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_commit && w_sel[i]) begin
                    r_regs[i] <= r_data;
                end
            end
            // A violation in the same cycle as a clear keeps the interrupt set.
            if (w_viol) begin
                if (r_viol_count != '1) begin
                    r_viol_count <= r_viol_count + 1'b1;
                end
                r_viol_irq <= 1'b1;
            end else if (i_viol_clr) begin
                r_viol_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        o_reg_q = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            o_reg_q[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

    assign o_lock_q         = r_lock | {NUM_REGS{r_lock_all}};
    assign o_viol_count     = r_viol_count;
    assign o_viol_irq       = r_viol_irq;
    assign io_bus.wr_ready  = (r_state == StIdle);
    assign io_bus.rsp_valid = (r_state == StResp);
    assign io_bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_lock_reg_bank.sv
// Bench for lock_reg_bank: directed scenarios plus random traffic, responses checked
// by a queue-based scoreboard against an array model of the register rules.
module tb_lock_reg_bank;
    localparam int unsigned NR = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 2;
    // reg0 mono, reg1 once, reg2 gated, reg3 reserved, reg4 mono, reg5 once
    localparam logic [2*NR-1:0] TB_MODE = {2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    localparam logic [1:0] E_OK = 2'b00, E_LOCKED = 2'b01, E_ROLLBACK = 2'b10, E_BAD = 2'b11;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lock_set = 1'b0;
    logic [AW-1:0]     lock_idx = '0;
    logic              lock_all = 1'b0;
    logic              viol_clr = 1'b0;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     lock_q;
    logic [CW-1:0]     viol_count;
    logic              viol_irq;

    lock_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    lock_reg_bank #(
        .NUM_REGS(NR), .DATA_W(DW), .MODE(TB_MODE), .RST_VAL('0), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .io_bus(bus), .i_lock_set(lock_set), .i_lock_idx(lock_idx),
        .i_lock_all(lock_all), .o_reg_q(reg_q), .o_lock_q(lock_q), .o_viol_count(viol_count),
        .o_viol_irq(viol_irq), .i_viol_clr(viol_clr)
    );

    always #5 clk = ~clk;

    // Reference model: kind 0 gated, 1 write-once, 2 monotonic
    int          m_kind [NR] = '{2, 1, 0, 0, 2, 1};
    logic [31:0] m_val [NR];
    bit          m_lk [NR];
    bit          m_all;
    int          m_cnt;
    bit          m_irq;

    logic [1:0] exp_q [$];
    int n_push = 0, n_rsp = 0;
    int n_checks = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_val[i] = '0;
            m_lk[i]  = 1'b0;
        end
        m_all = 1'b0;
        m_cnt = 0;
        m_irq = 1'b0;
    endfunction

    function automatic logic [1:0] model_write(input int a, input logic [31:0] d);
        logic [1:0] e;
        if (a >= NR) e = E_BAD;
        else if (m_lk[a] || m_all) e = E_LOCKED;
        else if (m_kind[a] == 2 && d < m_val[a]) e = E_ROLLBACK;
        else begin
            e = E_OK;
            m_val[a] = d;
            if (m_kind[a] == 1) m_lk[a] = 1'b1;
        end
        if (e != E_OK) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_irq = 1'b1;
        end
        return e;
    endfunction

    task automatic check_state();
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reg%0d", i), reg_q[i*DW +: DW], m_val[i]);
            chk($sformatf("lock%0d", i), 32'(lock_q[i]), 32'(m_lk[i] | m_all));
        end
        chk("viol_count", 32'(viol_count), m_cnt);
        chk("viol_irq", 32'(viol_irq), 32'(m_irq));
    endtask

    // Scoreboard monitor: one pop per accepted response.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0d expected none", bus.rsp_err);
            end else begin
                chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q.pop_front()));
                n_rsp++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_lock(input int idx);
        @(posedge clk); #1;
        lock_set = 1'b1;
        lock_idx = AW'(idx);
        if (idx < NR) m_lk[idx] = 1'b1;
        @(posedge clk); #1 lock_set = 1'b0;
    endtask

    task automatic pulse_lock_all();
        @(posedge clk); #1;
        lock_all = 1'b1;
        m_all = 1'b1;
        @(posedge clk); #1 lock_all = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        viol_clr = 1'b1;
        m_irq = 1'b0;
        @(posedge clk); #1 viol_clr = 1'b0;
    endtask

    // hold < 0: rsp_ready high throughout; otherwise hold it low for 'hold' cycles of RESP.
    // rst_mode: 0 none, 1 reset at the CHECK edge, 2 reset during RESP.
    task automatic do_write(input int a, input logic [31:0] d, input int hold, input bit la_chk,
                            input bit clr_chk, input int rst_mode);
        logic [1:0] e;
        bit ok;
        e = E_OK;
        @(posedge clk); #1;
        bus.wr_valid = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        bus.rsp_ready = (hold < 0);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("wr_ready_wait");
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        if (la_chk) begin
            lock_all = 1'b1;
            m_all = 1'b1;
        end
        if (clr_chk) begin
            viol_clr = 1'b1;
            m_irq = 1'b0;
        end
        if (rst_mode == 1) rst = 1'b1;
        else begin
            e = model_write(a, d);
            if (rst_mode == 0) begin
                exp_q.push_back(e);
                n_push++;
            end
        end
        @(posedge clk); #1;
        lock_all = 1'b0;
        viol_clr = 1'b0;
        if (rst_mode != 0) begin
            if (rst_mode == 2) begin
                rst = 1'b1;
                @(posedge clk); #1;
            end
            rst = 1'b0;
            model_reset();
            @(negedge clk);
            chk("rsp_valid_after_rst", 32'(bus.rsp_valid), 0);
            chk("wr_ready_after_rst", 32'(bus.wr_ready), 1);
            check_state();
            return;
        end
        if (hold >= 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_rsp_valid", 32'(bus.rsp_valid), 1);
                chk("hold_rsp_err", 32'(bus.rsp_err), 32'(e));
                chk("hold_wr_ready", 32'(bus.wr_ready), 0);
            end
            @(posedge clk); #1 bus.rsp_ready = 1'b1;
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (n_rsp == n_push) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail("rsp_wait");
            exp_q.delete();
            n_rsp = n_push;
        end
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_state();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        do_reset();
        @(negedge clk);
        chk("reset_wr_ready", 32'(bus.wr_ready), 1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 0);
        check_state();

        do_write(2, 32'hA5, -1, 0, 0, 0);
        pulse_lock(2);
        do_write(2, 32'h5A, -1, 0, 0, 0);
        do_write(1, 32'h11, 1, 0, 0, 0);
        do_write(1, 32'h22, -1, 0, 0, 0);
        do_write(0, 32'd5, 0, 0, 0, 0);
        do_write(0, 32'd5, -1, 0, 0, 0);
        do_write(0, 32'd4, -1, 0, 0, 0);
        do_write(0, 32'hFFFF_FFFF, 2, 0, 0, 0);
        do_write(0, 32'd0, -1, 0, 0, 0);

        do_reset();
        do_write(NR, 32'h1, 4, 0, 0, 0);
        do_write(7, 32'h2, -1, 0, 0, 0);
        do_write(NR, 32'h3, -1, 0, 0, 0);
        pulse_lock(7);
        do_write(7, 32'h4, -1, 0, 0, 0);
        pulse_clr();
        do_write(NR, 32'h5, -1, 0, 1, 0);

        do_reset();
        do_write(3, 32'h33, -1, 1, 0, 0);
        do_write(4, 32'h44, 0, 0, 0, 2);
        do_write(0, 32'h77, -1, 0, 0, 1);

        for (int it = 0; it < 250; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                int a;
                int h;
                logic [31:0] d;
                a = int'($urandom_range(0, 7));
                d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
                h = int'($urandom_range(0, 4)) - 1;
                do_write(a, d, h, 0, ($urandom_range(0, 9) == 0), 0);
            end else if (r < 82) pulse_lock(int'($urandom_range(0, 7)));
            else if (r < 90) pulse_clr();
            else if (r < 92) pulse_lock_all();
            else do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
